// File: rtl/frame_buf_arb.sv
// frame_buf_arb: arbitrates one write client and one read client onto a single
// frame-buffer memory port, one transaction outstanding at a time.
// Latency: ack 1 cycle after the IDLE sample; rd_valid RD_LAT+2 cycles after it.
// Backpressure: requesters hold req/addr/data until ack; no new grant until IDLE.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   wr_req/wr_req_addr/wr_req_data   write request in, wr_ack pulse out
//   rd_req/rd_req_addr               read request in, rd_ack pulse out
//   rd_valid/rd_resp_data            read response (data held until next rd_valid)
//   mem_*                            memory port, active-low strobes
//   busy                             high whenever the FSM is not in IDLE
//
// Build option: define FRAME_ARB_RD_PRIORITY_EN to make reads win ties, with a
// forced write grant after WR_STARVE_MAX consecutive read grants against a
// pending write. Undefined (default): ties are resolved round-robin.
module frame_buf_arb #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 29,
  parameter int RD_LAT        = 2,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  mem_wr_en_n,
  output logic                  mem_rd_en_n,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  localparam logic [3:0] RD_LAT_L = 4'(RD_LAT);

  state_t     state, state_nx;
  logic       grant_wr, grant_rd;
  logic       tie_to_wr;
  logic [3:0] wait_cnt;
  logic       rd_last;  // final RD_WAIT cycle: memory data is valid now

`ifdef FRAME_ARB_RD_PRIORITY_EN
  localparam int SW = $clog2(WR_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(WR_STARVE_MAX);
  logic [SW-1:0] starve_cnt;

  // Reads win ties until the write has lost WR_STARVE_MAX times in a row.
  assign tie_to_wr = (starve_cnt >= STARVE_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!wr_req || grant_wr)
        starve_cnt <= '0;
      else if (grant_rd && starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic last_grant_wr;  // 0 = last grant was a read, so write wins the first tie

  assign tie_to_wr = !last_grant_wr;

  always_ff @(posedge clk) begin
    if (reset)
      last_grant_wr <= 1'b0;
    else if (grant_wr)
      last_grant_wr <= 1'b1;
    else if (grant_rd)
      last_grant_wr <= 1'b0;
  end
`endif

  assign rd_last = (state == RD_WAIT) && (wait_cnt == 4'd1);

  always_comb begin
    state_nx = state;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && rd_req) begin
          grant_wr = tie_to_wr;
          grant_rd = !tie_to_wr;
        end else begin
          grant_wr = wr_req;
          grant_rd = rd_req;
        end
        if (grant_wr)
          state_nx = WR;
        else if (grant_rd)
          state_nx = RD;
      end
      WR:      state_nx = IDLE;
      RD:      state_nx = RD_WAIT;
      RD_WAIT: if (rd_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the grant/next-state decision so that they are
  // valid for the whole WR/RD/RD_WAIT cycle they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_resp_data <= '0;
      mem_wr_en_n  <= 1'b1;
      mem_rd_en_n  <= 1'b1;
      mem_wr_addr  <= '0;
      mem_rd_addr  <= '0;
      mem_wr_data  <= '0;
      busy         <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      state       <= state_nx;
      wr_ack      <= grant_wr;
      rd_ack      <= grant_rd;
      mem_wr_en_n <= !grant_wr;
      mem_rd_en_n <= !grant_rd;
      busy        <= (state_nx != IDLE);
      rd_valid    <= rd_last;
      if (grant_wr) begin
        mem_wr_addr <= wr_req_addr;
        mem_wr_data <= wr_req_data;
      end
      if (grant_rd)
        mem_rd_addr <= rd_req_addr;
      if (rd_last)
        rd_resp_data <= mem_rd_data;
      if (state == RD)
        wait_cnt <= RD_LAT_L;
      else if (state == RD_WAIT)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

endmodule
